// File: rtl/readout_pkg.sv
// Shared types and helpers for the cochlea readout bus receiver.
// Pure declarations: no latency, no flow control.
// Backpressure: n/a.
package readout_pkg;

    localparam int CNT_W   = 19;
    localparam int NCH_MAX = 16;
    localparam int CH_W    = 5;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            eve;
        logic            pol;
    } ro_word_t;

    // Index of the lowest set bit; returns 0 for k == 0, callers handle the wrap slot.
    function automatic logic [CH_W-1:0] lsb_index(input logic [31:0] k);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (k[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ro_sync_fifo.sv
// Generic synchronous FIFO with a registered head word and drop-on-full.
// Latency: a word pushed into an empty FIFO is at the head one cycle after the push edge.
// Backpressure: push while full without a pop is discarded and pulses drop; pop while empty is ignored.
module ro_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push_eff;
    logic          pop_eff;
    logic          head_from_push;
    logic [W-1:0]  head_nxt;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign drop     = push && full && !pop_eff;

    assign rd_nxt    = rd_ptr + AW'(pop_eff);
    assign count_nxt = count + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
    // The incoming word becomes the head when nothing older survives this edge.
    assign head_from_push = ((count - (AW+1)'(pop_eff)) == '0);

    always_comb begin
        head_nxt = head_dat;
        if (count_nxt != '0) begin
            head_nxt = head_from_push ? push_dat : mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_dat <= '0;
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_nxt;
            count    <= count_nxt;
            head_dat <= head_nxt;
        end
    end

endmodule

// File: rtl/readout_deframer.sv
// Deframes the gray-scheduled cochlea readout bus into tagged event words plus a per-channel bank.
// Latency: bus sampled at the edge ending the slot; word at FIFO head and bank updated one cycle later.
// Backpressure: out_valid/out_ready on a small FIFO; words captured while full are dropped and overflow sticks.
module readout_deframer #(
    parameter int CNT_W      = readout_pkg::CNT_W,
    parameter int NCH        = readout_pkg::NCH_MAX,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           en,
    input  logic           bus_eve,
    input  logic           bus_pol_eve,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4:0]     out_ch,
    output logic           out_eve,
    output logic           out_pol,
    output logic [NCH-1:0] ch_eve,
    output logic [NCH-1:0] ch_pol,
    output logic           overflow
);

    import readout_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  owner;
    logic             capture;
    ro_word_t         cap_word;
    ro_word_t         head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;

    // cnt == 0 is the wrap slot where the top gray bit toggles.
    always_comb begin
        owner = lsb_index(32'(cnt));
        if (cnt == '0) owner = CH_W'(CNT_W - 1);
    end

    assign capture  = en && (int'(owner) < NCH);
    assign cap_word = '{ch: owner, eve: bus_eve, pol: bus_pol_eve};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt      <= '0;
            ch_eve   <= '0;
            ch_pol   <= '0;
            overflow <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (capture) begin
                for (int i = 0; i < NCH; i++) begin
                    if (owner == CH_W'(i)) begin
                        ch_eve[i] <= bus_eve;
                        ch_pol[i] <= bus_pol_eve;
                    end
                end
            end
            overflow <= overflow | fifo_drop;
        end
    end

    ro_sync_fifo #(
        .W     ($bits(ro_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .push     (capture),
        .push_dat (cap_word),
        .pop      (out_ready),
        .head_dat (head_word),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign out_valid = !fifo_empty;
    assign out_ch    = head_word.ch;
    assign out_eve   = head_word.eve;
    assign out_pol   = head_word.pol;

    a_drop_only_when_full: assert property (@(posedge clk) disable iff (!rstb) fifo_drop |-> fifo_full);

endmodule

// File: tb/tb_readout_deframer.sv
// Directed bench for readout_deframer: default build plus a CNT_W=4/NCH=3 build sharing clock and reset.
// Both instances see the same bus lines, enable and ready.
module tb_readout_deframer;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        en = 1'b0;
    logic        bus_eve = 1'b0;
    logic        bus_pol_eve = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_eve, out_pol, overflow;
    logic [4:0]  out_ch;
    logic [15:0] ch_eve, ch_pol;
    logic        s_out_valid, s_out_eve, s_out_pol, s_overflow;
    logic [4:0]  s_out_ch;
    logic [2:0]  s_ch_eve, s_ch_pol;

    int total = 0;
    int bad = 0;
    int rises = 0;

    int exp_big[8]    = '{0, 1, 0, 2, 0, 1, 0, 3};
    int exp_small[16] = '{-1, 0, 1, 0, 2, 0, 1, 0, -1, 0, 1, 0, 2, 0, 1, 0};

    always #5 clk = ~clk;

    readout_deframer dut (
        .clk(clk), .rstb(rstb), .en(en), .bus_eve(bus_eve), .bus_pol_eve(bus_pol_eve),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_eve(out_eve),
        .out_pol(out_pol), .ch_eve(ch_eve), .ch_pol(ch_pol), .overflow(overflow)
    );

    readout_deframer #(.CNT_W(4), .NCH(3), .FIFO_DEPTH(4)) dut_small (
        .clk(clk), .rstb(rstb), .en(en), .bus_eve(bus_eve), .bus_pol_eve(bus_pol_eve),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch), .out_eve(s_out_eve),
        .out_pol(s_out_pol), .ch_eve(s_ch_eve), .ch_pol(s_ch_pol), .overflow(s_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        rises++;
    endtask

    // Release lands 1 time unit after an edge, so rises counts the DUT counter value.
    task automatic do_reset();
        rstb = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        rises = 0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
        total++; if (out_ch !== 5'd0) begin bad++; $display("FAIL rst_out_ch got=%0h want=0", out_ch); end
        total++; if ({out_eve, out_pol} !== 2'b00) begin bad++; $display("FAIL rst_out_bits got=%0h want=0", {out_eve, out_pol}); end
        total++; if (ch_eve !== 16'h0) begin bad++; $display("FAIL rst_ch_eve got=%0h want=0", ch_eve); end
        total++; if (ch_pol !== 16'h0) begin bad++; $display("FAIL rst_ch_pol got=%0h want=0", ch_pol); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0h want=0", overflow); end
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst_small_valid got=%0h want=0", s_out_valid); end
    endtask

    task automatic test_stream();
        en = 1'b1; bus_eve = 1'b1; bus_pol_eve = 1'b0; out_ready = 1'b1;
        do_reset();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_slot0 got=%0h want=0", out_valid); end
        for (int r = 2; r <= 32769; r++) begin
            tick();
            if (r <= 9) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid r=%0d got=%0h want=1", r, out_valid); end
                total++; if (out_ch !== 5'(exp_big[r-2])) begin bad++; $display("FAIL stream_ch r=%0d got=%0d want=%0d", r, out_ch, exp_big[r-2]); end
                total++; if ({out_eve, out_pol} !== 2'b10) begin bad++; $display("FAIL stream_bits r=%0d got=%0h want=2", r, {out_eve, out_pol}); end
            end
            if (r == 9) begin
                total++; if (ch_eve !== 16'h000F) begin bad++; $display("FAIL stream_bank8 got=%0h want=000f", ch_eve); end
            end
            if (r == 32768) begin
                total++; if (ch_eve !== 16'h7FFF) begin bad++; $display("FAIL stream_bank_pre got=%0h want=7fff", ch_eve); end
            end
            if (r == 32769) begin
                total++; if (ch_eve !== 16'hFFFF) begin bad++; $display("FAIL stream_bank_all got=%0h want=ffff", ch_eve); end
                total++; if (ch_pol !== 16'h0000) begin bad++; $display("FAIL stream_pol_bank got=%0h want=0", ch_pol); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid_end got=%0h want=1", out_valid); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_overflow got=%0h want=0", overflow); end
            end
        end
    endtask

    task automatic test_ch2_only();
        en = 1'b1; bus_eve = 1'b0; bus_pol_eve = 1'b0; out_ready = 1'b1;
        do_reset();
        for (int r = 1; r <= 32; r++) begin
            tick();
            if (r >= 2 && r <= 9) begin
                total++; if (out_ch !== 5'(exp_big[r-2])) begin bad++; $display("FAIL ch2_ch r=%0d got=%0d want=%0d", r, out_ch, exp_big[r-2]); end
                total++; if (out_eve !== (r == 5)) begin bad++; $display("FAIL ch2_eve r=%0d got=%0h want=%0h", r, out_eve, (r == 5)); end
            end
            if (r == 32) begin
                total++; if (ch_eve !== 16'h0004) begin bad++; $display("FAIL ch2_bank got=%0h want=0004", ch_eve); end
            end
            bus_eve = ((r % 8) == 4);
        end
        bus_eve = 1'b0;
    endtask

    task automatic test_backpressure();
        en = 1'b1; bus_eve = 1'b1; bus_pol_eve = 1'b0; out_ready = 1'b0;
        do_reset();
        for (int r = 1; r <= 10; r++) begin
            tick();
            if (r == 5) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid5 got=%0h want=1", out_valid); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_no_overflow_yet got=%0h want=0", overflow); end
            end
            if (r == 6) begin
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%0h want=1", overflow); end
            end
        end
        total++; if (out_ch !== 5'd0) begin bad++; $display("FAIL bp_head_hold got=%0d want=0", out_ch); end
        out_ready = 1'b1; en = 1'b0;
        tick();
        total++; if (out_ch !== 5'd1) begin bad++; $display("FAIL bp_drain1 got=%0d want=1", out_ch); end
        tick();
        total++; if (out_ch !== 5'd0) begin bad++; $display("FAIL bp_drain2 got=%0d want=0", out_ch); end
        tick();
        total++; if ({out_valid, out_ch, out_eve} !== {1'b1, 5'd2, 1'b1}) begin bad++; $display("FAIL bp_drain3 got=%0h want=45", {out_valid, out_ch, out_eve}); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h want=0", out_valid); end
        total++; if (out_ch !== 5'd2) begin bad++; $display("FAIL bp_idle_hold got=%0d want=2", out_ch); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow_sticky got=%0h want=1", overflow); end
    endtask

    task automatic test_enable_gate();
        en = 1'b0; bus_eve = 1'b1; bus_pol_eve = 1'b1; out_ready = 1'b1;
        do_reset();
        for (int r = 1; r <= 10; r++) begin
            tick();
            if (r <= 8) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL en_off_valid r=%0d got=%0h want=0", r, out_valid); end
            end
            if (r == 8) begin
                total++; if (ch_eve !== 16'h0) begin bad++; $display("FAIL en_off_bank got=%0h want=0", ch_eve); end
                en = 1'b1;
            end
            if (r == 9) begin
                total++; if ({out_valid, out_ch, out_pol} !== {1'b1, 5'd3, 1'b1}) begin bad++; $display("FAIL en_first got=%0h want=47", {out_valid, out_ch, out_pol}); end
            end
            if (r == 10) begin
                total++; if (out_ch !== 5'd0) begin bad++; $display("FAIL en_second got=%0d want=0", out_ch); end
            end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; bus_eve = 1'b1; bus_pol_eve = 1'b1; out_ready = 1'b0;
        do_reset();
        for (int r = 1; r <= 4; r++) tick();
        total++; if (ch_pol !== 16'h0003) begin bad++; $display("FAIL mid_pre_bank got=%0h want=0003", ch_pol); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0h want=1", out_valid); end
        #2;
        rstb = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0h want=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%0h want=0", overflow); end
        total++; if ({ch_eve, ch_pol} !== 32'h0) begin bad++; $display("FAIL mid_bank got=%0h want=0", {ch_eve, ch_pol}); end
        total++; if (out_ch !== 5'd0) begin bad++; $display("FAIL mid_out_ch got=%0d want=0", out_ch); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rstb = 1'b1;
        rises = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_restart0 got=%0h want=0", out_valid); end
        tick();
        total++; if ({out_valid, out_ch} !== {1'b1, 5'd0}) begin bad++; $display("FAIL mid_restart1 got=%0h want=20", {out_valid, out_ch}); end
        tick();
        total++; if (out_ch !== 5'd1) begin bad++; $display("FAIL mid_restart2 got=%0d want=1", out_ch); end
    endtask

    task automatic test_small_wrap();
        en = 1'b1; bus_eve = 1'b1; bus_pol_eve = 1'b1; out_ready = 1'b1;
        do_reset();
        for (int r = 1; r <= 20; r++) begin
            int e;
            tick();
            e = exp_small[(r - 1) % 16];
            if (e < 0) begin
                total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL small_gap r=%0d got=%0h want=0", r, s_out_valid); end
            end else begin
                total++; if ({s_out_valid, s_out_ch} !== {1'b1, 5'(e)}) begin bad++; $display("FAIL small_word r=%0d got=%0h want=%0h", r, {s_out_valid, s_out_ch}, {1'b1, 5'(e)}); end
            end
        end
        total++; if (s_ch_eve !== 3'b111) begin bad++; $display("FAIL small_bank got=%0h want=7", s_ch_eve); end
        total++; if (s_overflow !== 1'b0) begin bad++; $display("FAIL small_overflow got=%0h want=0", s_overflow); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ch2_only();
        test_backpressure();
        test_enable_gate();
        test_reset_mid();
        test_small_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
